// File: rtl/pixel_color_scheduler.sv
// Pixel colour scheduler: issues block-table lookups to a fixed-latency shading pipeline,
// then re-pairs returned colours with their pixel tags in issue order under a credit limit.
module pixel_color_scheduler #(
  parameter int NUM_BLOCKS = 12,
  parameter int OUT_DEPTH  = 64
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         hit_valid_in,
  output logic                         hit_ready_out,
  input  logic [10:0]                  hit_x_in,
  input  logic [9:0]                   hit_y_in,
  input  logic [NUM_BLOCKS-1:0]        hit_block_in,
  input  logic [31:0]                  hit_ray_x_in,
  input  logic [31:0]                  hit_ray_y_in,
  input  logic [31:0]                  hit_ray_z_in,
  input  logic [31:0]                  hit_t_in,
  input  logic [NUM_BLOCKS-1:0][31:0]  block_pos_x_in,
  input  logic [NUM_BLOCKS-1:0][31:0]  block_pos_y_in,
  input  logic [NUM_BLOCKS-1:0][31:0]  block_pos_z_in,
  input  logic [NUM_BLOCKS-1:0][31:0]  block_mat_x_in,
  input  logic [NUM_BLOCKS-1:0][31:0]  block_mat_y_in,
  input  logic [NUM_BLOCKS-1:0][31:0]  block_mat_z_in,
  input  logic [NUM_BLOCKS-1:0][1:0]   block_dir_in,
  input  logic [31:0]                  bg_r_in,
  input  logic [31:0]                  bg_g_in,
  input  logic [31:0]                  bg_b_in,
  output logic                         pc_valid_out,
  output logic [31:0]                  pc_pos_x_out,
  output logic [31:0]                  pc_pos_y_out,
  output logic [31:0]                  pc_pos_z_out,
  output logic [31:0]                  pc_mat_x_out,
  output logic [31:0]                  pc_mat_y_out,
  output logic [31:0]                  pc_mat_z_out,
  output logic [1:0]                   pc_dir_out,
  output logic [31:0]                  pc_ray_x_out,
  output logic [31:0]                  pc_ray_y_out,
  output logic [31:0]                  pc_ray_z_out,
  output logic [31:0]                  pc_t_out,
  input  logic                         pc_valid_in,
  input  logic [31:0]                  pc_r_in,
  input  logic [31:0]                  pc_g_in,
  input  logic [31:0]                  pc_b_in,
  output logic                         pix_valid_out,
  input  logic                         pix_ready_in,
  output logic [10:0]                  pix_x_out,
  output logic [9:0]                   pix_y_out,
  output logic [31:0]                  pix_r_out,
  output logic [31:0]                  pix_g_out,
  output logic [31:0]                  pix_b_out,
  output logic                         pix_hit_out,
  output logic [$clog2(OUT_DEPTH):0]   in_flight_out,
  output logic                         overflow_err_out
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [CW-1:0] FULL = CW'(OUT_DEPTH);

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        hit;
  } tag_t;

  typedef struct packed {
    tag_t        tag;
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
  } pix_t;

  tag_t tag_mem [OUT_DEPTH];
  pix_t out_mem [OUT_DEPTH];

  logic [PW-1:0] tag_wr_ptr, tag_rd_ptr, out_wr_ptr, out_rd_ptr;
  logic [CW-1:0] tag_count, out_count;
  logic [CW:0]   used;
  logic [IW-1:0] sel;
  logic          is_hit, accept, tag_pop, out_push, out_pop, err_set;
  tag_t          ret_tag;
  pix_t          push_word, head;

  // Ready is gated by reset so the upstream sees no credit while the block is held in reset.
  assign used          = {1'b0, tag_count} + {1'b0, out_count};
  assign hit_ready_out = rst_in && (used < {1'b0, FULL});
  assign accept        = hit_valid_in && hit_ready_out;
  assign is_hit        = |hit_block_in;

  always_comb begin
    sel = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (hit_block_in[i]) sel = IW'(i);
    end
  end

  // A return only fits in the output FIFO if it is not full, or a pop frees a slot this cycle.
  assign pix_valid_out = (out_count != '0);
  assign out_pop       = pix_valid_out && pix_ready_in;
  assign tag_pop       = pc_valid_in && (tag_count != '0);
  assign out_push      = tag_pop && ((out_count != FULL) || out_pop);
  assign err_set       = pc_valid_in && ((tag_count == '0) || ((out_count == FULL) && !out_pop));

  assign ret_tag = tag_mem[tag_rd_ptr];

  always_comb begin
    push_word     = '0;
    push_word.tag = ret_tag;
    push_word.r   = ret_tag.hit ? pc_r_in : bg_r_in;
    push_word.g   = ret_tag.hit ? pc_g_in : bg_g_in;
    push_word.b   = ret_tag.hit ? pc_b_in : bg_b_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc_valid_out <= 1'b0;
      pc_pos_x_out <= '0;
      pc_pos_y_out <= '0;
      pc_pos_z_out <= '0;
      pc_mat_x_out <= '0;
      pc_mat_y_out <= '0;
      pc_mat_z_out <= '0;
      pc_dir_out   <= '0;
      pc_ray_x_out <= '0;
      pc_ray_y_out <= '0;
      pc_ray_z_out <= '0;
      pc_t_out     <= '0;
    end else begin
      pc_valid_out <= accept;
      if (accept) begin
        pc_pos_x_out <= is_hit ? block_pos_x_in[sel] : '0;
        pc_pos_y_out <= is_hit ? block_pos_y_in[sel] : '0;
        pc_pos_z_out <= is_hit ? block_pos_z_in[sel] : '0;
        pc_mat_x_out <= is_hit ? block_mat_x_in[sel] : '0;
        pc_mat_y_out <= is_hit ? block_mat_y_in[sel] : '0;
        pc_mat_z_out <= is_hit ? block_mat_z_in[sel] : '0;
        pc_dir_out   <= is_hit ? block_dir_in[sel]   : '0;
        pc_ray_x_out <= hit_ray_x_in;
        pc_ray_y_out <= hit_ray_y_in;
        pc_ray_z_out <= hit_ray_z_in;
        pc_t_out     <= hit_t_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept)   tag_mem[tag_wr_ptr] <= '{x: hit_x_in, y: hit_y_in, hit: is_hit};
    if (out_push) out_mem[out_wr_ptr] <= push_word;
  end

  // A return that cannot be stored still consumes its tag so later returns stay paired.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tag_wr_ptr       <= '0;
      tag_rd_ptr       <= '0;
      tag_count        <= '0;
      out_wr_ptr       <= '0;
      out_rd_ptr       <= '0;
      out_count        <= '0;
      overflow_err_out <= 1'b0;
    end else begin
      if (accept)   tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + 1'b1;
      if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
      case ({accept, tag_pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: ;
      endcase
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + 1'b1;
        2'b01:   out_count <= out_count - 1'b1;
        default: ;
      endcase
      if (err_set) overflow_err_out <= 1'b1;
    end
  end

  assign head          = out_mem[out_rd_ptr];
  assign pix_x_out     = pix_valid_out ? head.tag.x   : '0;
  assign pix_y_out     = pix_valid_out ? head.tag.y   : '0;
  assign pix_hit_out   = pix_valid_out ? head.tag.hit : 1'b0;
  assign pix_r_out     = pix_valid_out ? head.r       : '0;
  assign pix_g_out     = pix_valid_out ? head.g       : '0;
  assign pix_b_out     = pix_valid_out ? head.b       : '0;
  assign in_flight_out = tag_count;

endmodule

// File: tb/tb_pixel_color_scheduler.sv
// Bench for pixel_color_scheduler: fixed-latency shading stub, queue-based reference model
// compared every cycle, plus directed cases with hand-computed expectations.
module tb_pixel_color_scheduler;

  localparam int NB    = 12;
  localparam int LAT   = 40;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              hit_valid, hit_ready, pix_ready;
  logic [10:0]       hit_x;
  logic [9:0]        hit_y;
  logic [NB-1:0]     hit_block;
  logic [31:0]       ray_x, ray_y, ray_z, hit_t;
  logic [NB-1:0][31:0] pos_x, pos_y, pos_z, mat_x, mat_y, mat_z;
  logic [NB-1:0][1:0]  dir;
  logic [31:0]       bg_r, bg_g, bg_b;
  logic              pc_valid_out, pc_valid_in;
  logic [31:0]       pc_pos_x, pc_pos_y, pc_pos_z, pc_mat_x, pc_mat_y, pc_mat_z;
  logic [1:0]        pc_dir;
  logic [31:0]       pc_ray_x, pc_ray_y, pc_ray_z, pc_t;
  logic [31:0]       pc_r, pc_g, pc_b;
  logic              pix_valid, pix_hit, overflow_err;
  logic [10:0]       pix_x;
  logic [9:0]        pix_y;
  logic [31:0]       pix_r, pix_g, pix_b;
  logic [6:0]        in_flight;

  pixel_color_scheduler #(.NUM_BLOCKS(NB), .OUT_DEPTH(DEPTH)) dut (
    .clk_in(clk), .rst_in(rst_n),
    .hit_valid_in(hit_valid), .hit_ready_out(hit_ready),
    .hit_x_in(hit_x), .hit_y_in(hit_y), .hit_block_in(hit_block),
    .hit_ray_x_in(ray_x), .hit_ray_y_in(ray_y), .hit_ray_z_in(ray_z), .hit_t_in(hit_t),
    .block_pos_x_in(pos_x), .block_pos_y_in(pos_y), .block_pos_z_in(pos_z),
    .block_mat_x_in(mat_x), .block_mat_y_in(mat_y), .block_mat_z_in(mat_z),
    .block_dir_in(dir),
    .bg_r_in(bg_r), .bg_g_in(bg_g), .bg_b_in(bg_b),
    .pc_valid_out(pc_valid_out),
    .pc_pos_x_out(pc_pos_x), .pc_pos_y_out(pc_pos_y), .pc_pos_z_out(pc_pos_z),
    .pc_mat_x_out(pc_mat_x), .pc_mat_y_out(pc_mat_y), .pc_mat_z_out(pc_mat_z),
    .pc_dir_out(pc_dir),
    .pc_ray_x_out(pc_ray_x), .pc_ray_y_out(pc_ray_y), .pc_ray_z_out(pc_ray_z), .pc_t_out(pc_t),
    .pc_valid_in(pc_valid_in), .pc_r_in(pc_r), .pc_g_in(pc_g), .pc_b_in(pc_b),
    .pix_valid_out(pix_valid), .pix_ready_in(pix_ready),
    .pix_x_out(pix_x), .pix_y_out(pix_y),
    .pix_r_out(pix_r), .pix_g_out(pix_g), .pix_b_out(pix_b), .pix_hit_out(pix_hit),
    .in_flight_out(in_flight), .overflow_err_out(overflow_err)
  );

  // The shading stub derives its colour from the job fields so that misrouted attributes show up.
  function automatic logic [31:0] shade_r(input logic [31:0] px, input logic [31:0] t);
    return px ^ t;
  endfunction
  function automatic logic [31:0] shade_g(input logic [31:0] mx, input logic [31:0] ry);
    return mx + ry;
  endfunction
  function automatic logic [31:0] shade_b(input logic [1:0] d, input logic [31:0] rz);
    return {30'd0, d} ^ rz;
  endfunction

  logic [LAT-1:0] stub_v = '0;
  logic [31:0] stub_r [LAT];
  logic [31:0] stub_g [LAT];
  logic [31:0] stub_b [LAT];

  always @(posedge clk) begin
    stub_v   <= {stub_v[LAT-2:0], pc_valid_out};
    stub_r[0] <= shade_r(pc_pos_x, pc_t);
    stub_g[0] <= shade_g(pc_mat_x, pc_ray_y);
    stub_b[0] <= shade_b(pc_dir, pc_ray_z);
    for (int i = 1; i < LAT; i++) begin
      stub_r[i] <= stub_r[i-1];
      stub_g[i] <= stub_g[i-1];
      stub_b[i] <= stub_b[i-1];
    end
  end
  assign pc_valid_in = stub_v[LAT-1];
  assign pc_r = stub_r[LAT-1];
  assign pc_g = stub_g[LAT-1];
  assign pc_b = stub_b[LAT-1];

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic        hit;
    logic [31:0] r, g, b;
  } pix_s;

  typedef struct {
    logic [31:0] px, py, pz, mx, my, mz, rx, ry, rz, t;
    logic [1:0]  d;
  } iss_s;

  int   n_checks = 0;
  int   n_fail = 0;
  pix_s exp_q[$];
  int   m_tags = 0;
  int   m_out = 0;
  bit   m_err = 1'b0;
  bit   iss_v = 1'b0;
  iss_s iss;
  bit   m_acc, m_ret, m_pop;
  int   m_idx;
  logic [NB-1:0] lowbit;
  pix_s m_new;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: every accepted hit is queued with its final colour; the head m_out
  // entries are the ones already returned and waiting in the output buffer.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      m_tags = 0;
      m_out  = 0;
      m_err  = 1'b0;
      iss_v  = 1'b0;
    end else begin
      m_acc = hit_valid && ((m_tags + m_out) < DEPTH);
      m_ret = pc_valid_in;
      m_pop = (m_out > 0) && pix_ready;
      if (m_ret) begin
        if (m_tags == 0) m_err = 1'b1;
        else if (m_out == DEPTH && !m_pop) begin
          m_err = 1'b1;
          exp_q.delete(m_out);
          m_tags--;
        end else begin
          m_tags--;
          m_out++;
        end
      end
      if (m_pop) begin
        void'(exp_q.pop_front());
        m_out--;
      end
      iss_v = m_acc;
      if (m_acc) begin
        lowbit = hit_block & (~hit_block + 1'b1);
        m_idx  = $clog2(lowbit);
        if (hit_block == '0) begin
          iss = '{px: 0, py: 0, pz: 0, mx: 0, my: 0, mz: 0, d: 0,
                  rx: ray_x, ry: ray_y, rz: ray_z, t: hit_t};
          m_new = '{x: hit_x, y: hit_y, hit: 1'b0, r: bg_r, g: bg_g, b: bg_b};
        end else begin
          iss = '{px: pos_x[m_idx], py: pos_y[m_idx], pz: pos_z[m_idx],
                  mx: mat_x[m_idx], my: mat_y[m_idx], mz: mat_z[m_idx], d: dir[m_idx],
                  rx: ray_x, ry: ray_y, rz: ray_z, t: hit_t};
          m_new = '{x: hit_x, y: hit_y, hit: 1'b1,
                    r: shade_r(pos_x[m_idx], hit_t),
                    g: shade_g(mat_x[m_idx], ray_y),
                    b: shade_b(dir[m_idx], ray_z)};
        end
        exp_q.push_back(m_new);
        m_tags++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check_output("hit_ready", 32'(hit_ready), 32'((m_tags + m_out) < DEPTH));
      check_output("in_flight", 32'(in_flight), 32'(m_tags));
      check_output("overflow_err", 32'(overflow_err), 32'(m_err));
      check_output("pix_valid", 32'(pix_valid), 32'(m_out > 0));
      if (pix_valid && m_out > 0) begin
        check_output("pix_x", 32'(pix_x), 32'(exp_q[0].x));
        check_output("pix_y", 32'(pix_y), 32'(exp_q[0].y));
        check_output("pix_hit", 32'(pix_hit), 32'(exp_q[0].hit));
        check_output("pix_r", pix_r, exp_q[0].r);
        check_output("pix_g", pix_g, exp_q[0].g);
        check_output("pix_b", pix_b, exp_q[0].b);
      end
      check_output("pc_valid", 32'(pc_valid_out), 32'(iss_v));
      if (pc_valid_out && iss_v) begin
        check_output("pc_pos_x", pc_pos_x, iss.px);
        check_output("pc_pos_y", pc_pos_y, iss.py);
        check_output("pc_pos_z", pc_pos_z, iss.pz);
        check_output("pc_mat_x", pc_mat_x, iss.mx);
        check_output("pc_mat_y", pc_mat_y, iss.my);
        check_output("pc_mat_z", pc_mat_z, iss.mz);
        check_output("pc_dir", 32'(pc_dir), 32'(iss.d));
        check_output("pc_ray_x", pc_ray_x, iss.rx);
        check_output("pc_ray_y", pc_ray_y, iss.ry);
        check_output("pc_ray_z", pc_ray_z, iss.rz);
        check_output("pc_t", pc_t, iss.t);
      end
    end
  end

  int pops = 0;
  int accs = 0;
  always @(posedge clk) begin
    if (rst_n && pix_valid && pix_ready) pops <= pops + 1;
    if (rst_n && hit_valid && hit_ready) accs <= accs + 1;
  end

  task automatic apply_stimulus(input logic v, input logic [NB-1:0] blk);
    hit_valid = v;
    hit_block = blk;
    hit_x     = 11'($urandom);
    hit_y     = 10'($urandom);
    ray_x     = $urandom;
    ray_y     = $urandom;
    ray_z     = $urandom;
    hit_t     = $urandom;
  endtask

  function automatic logic [NB-1:0] rand_block();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return '0;
    if (sel == 1) return NB'(1) << $urandom_range(0, NB - 1);
    return NB'($urandom);
  endfunction

  // Offers `total` hits, holding each until accepted, for at most `budget` cycles.
  task automatic offer_hits(input int total, input int budget, inout int taken);
    bit need_new;
    need_new = 1'b1;
    for (int c = 0; c < budget && taken < total; c++) begin
      @(negedge clk);
      if (need_new) apply_stimulus(1'b1, rand_block());
      need_new = hit_ready;
      if (hit_ready) taken++;
    end
    @(negedge clk);
    hit_valid = 1'b0;
  endtask

  int n, k, taken, pops0, accs0;
  logic [2:0]  rec_hit;
  logic [31:0] rec_r [3];

  initial begin
    apply_stimulus(1'b0, '0);
    pix_ready = 1'b1;
    for (int i = 0; i < NB; i++) begin
      pos_x[i] = $urandom; pos_y[i] = $urandom; pos_z[i] = $urandom;
      mat_x[i] = $urandom; mat_y[i] = $urandom; mat_z[i] = $urandom;
      dir[i]   = 2'($urandom);
    end
    pos_x[0] = 32'h44E10000; pos_y[0] = 32'h44E10000; pos_z[0] = 32'h447A0000;
    pos_x[1] = 32'h11111111; mat_x[1] = 32'h22222222;
    bg_r = $urandom; bg_g = $urandom; bg_b = $urandom;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_hit_ready", 32'(hit_ready), 32'd0);
    check_output("reset_pc_valid", 32'(pc_valid_out), 32'd0);
    check_output("reset_pix_valid", 32'(pix_valid), 32'd0);
    check_output("reset_in_flight", 32'(in_flight), 32'd0);
    #2 rst_n = 1'b1;

    // Single hit on block 0; stub red = pos_x ^ t is arranged to give 1.0f.
    @(negedge clk);
    apply_stimulus(1'b1, 12'h001);
    hit_x = 11'd100; hit_y = 10'd50; hit_t = 32'h7B610000;
    @(negedge clk);
    hit_valid = 1'b0;
    check_output("t1_pc_valid", 32'(pc_valid_out), 32'd1);
    check_output("t1_pc_pos_x", pc_pos_x, 32'h44E10000);
    check_output("t1_pc_pos_z", pc_pos_z, 32'h447A0000);
    n = 1;
    while (!pix_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("t1_latency", 32'(n), 32'(LAT + 2));
    check_output("t1_pix_r", pix_r, 32'h3F800000);
    check_output("t1_pix_hit", 32'(pix_hit), 32'd1);
    check_output("t1_pix_x", 32'(pix_x), 32'd100);
    check_output("t1_pix_y", 32'(pix_y), 32'd50);

    // Hit, miss, hit back to back.
    @(negedge clk); apply_stimulus(1'b1, 12'h010);
    @(negedge clk); apply_stimulus(1'b1, 12'h000);
    @(negedge clk); apply_stimulus(1'b1, 12'h800);
    @(negedge clk); hit_valid = 1'b0;
    k = 0; n = 0;
    while (k < 3 && n < 200) begin
      if (pix_valid) begin
        rec_hit[2-k] = pix_hit;
        rec_r[k] = pix_r;
        k++;
      end
      @(negedge clk);
      n++;
    end
    check_output("t2_count", 32'(k), 32'd3);
    check_output("t2_hit_pattern", 32'(rec_hit), 32'b101);
    check_output("t2_miss_bg", rec_r[1], bg_r);

    // Multi-hot block vector: block 1 wins.
    @(negedge clk); apply_stimulus(1'b1, 12'h006);
    @(negedge clk); hit_valid = 1'b0;
    check_output("t3_pc_pos_x", pc_pos_x, 32'h11111111);
    check_output("t3_pc_mat_x", pc_mat_x, 32'h22222222);
    repeat (LAT + 5) @(negedge clk);

    // Stalled output: exactly DEPTH hits accepted out of 100 offered.
    pix_ready = 1'b0;
    pops0 = pops;
    taken = 0;
    offer_hits(100, 150, taken);
    check_output("t4_accepted", 32'(taken), 32'(DEPTH));
    check_output("t4_ready_low", 32'(hit_ready), 32'd0);
    check_output("t4_no_err", 32'(overflow_err), 32'd0);
    pix_ready = 1'b1;
    offer_hits(100, 600, taken);
    repeat (LAT + 80) @(negedge clk);
    check_output("t4_all_out", 32'(pops - pops0), 32'd100);

    // Sit at the credit limit with sparse pops, then fully random traffic.
    pops0 = pops; accs0 = accs;
    pix_ready = 1'b0;
    taken = 0;
    offer_hits(1000, 150, taken);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      apply_stimulus(1'b1, rand_block());
      pix_ready = ($urandom_range(0, 3) == 0);
    end
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      apply_stimulus($urandom_range(0, 9) < 7, rand_block());
      pix_ready = ($urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    hit_valid = 1'b0; pix_ready = 1'b1;
    repeat (LAT + 150) @(negedge clk);
    check_output("t5_conservation", 32'(pops - pops0), 32'(accs - accs0));
    check_output("t5_drained", 32'(in_flight), 32'd0);

    // Asynchronous reset between edges with jobs still inside the shading stub.
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      apply_stimulus(1'b1, rand_block());
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    hit_valid = 1'b0;
    check_output("t6_rst_pc_valid", 32'(pc_valid_out), 32'd0);
    check_output("t6_rst_pix_valid", 32'(pix_valid), 32'd0);
    check_output("t6_rst_in_flight", 32'(in_flight), 32'd0);
    check_output("t6_rst_pc_pos_x", pc_pos_x, 32'd0);
    check_output("t6_rst_pix_x", 32'(pix_x), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    pops0 = pops;
    repeat (LAT + 5) @(negedge clk);
    check_output("t6_stray_err", 32'(overflow_err), 32'd1);
    check_output("t6_no_pix", 32'(pops - pops0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
